gate_down_counter: RTL and testbench
====================================

Name: gate_down_counter

Overview:
- Synchronous binary down-counter with parallel load; the decrementing counterpart of the team's 4-bit loadable up-counter.
- Produces a borrow output for cascading stages into wider down-counters.
- Optional auto-reload turns it into a periodic divider or interval timer.
- Sits alongside the up-counter in the counter library; a downstream stage chains by driving its count input from this block's borrow.

Parameters:
- WIDTH, 4, counter width in bits (legal range 2..16).
- AUTO_RELOAD, 0:
  - 0: the counter wraps 0 -> all-ones.
  - 1: the counter wraps 0 -> last loaded value.

Ports:
- clock  input  1  rising-edge clock; sole clock domain.
- clear  input  1  asynchronous, active-low reset.
- count  input  1  decrement enable; active only when load=0.
- load  input  1  synchronous parallel load; priority over count.
- inp  input  [0:WIDTH-1]  load value; index 0 is the LSB.
- out  output  [0:WIDTH-1]  registered count value; index 0 is the LSB.
- borrow  output  1  combinational: count & ~load & (out==0).
- zero  output  1  combinational: out==0.
- done  output  1  registered one-cycle pulse after a borrow cycle.

Behaviour:
- Bit order: index 0 is the LSB everywhere. Arithmetic is unsigned modulo 2^WIDTH.
- Internal state:
  - out register.
  - reload register rld, WIDTH bits; it exists only when AUTO_RELOAD=1, else tie it to all-ones.
  - done flop.
- Reset: clear=0 asynchronously forces out=0, rld=0 and done=0, regardless of clock.
  - Reset mid-count takes effect immediately, not at the next edge.
  - The first active edge after clear rises obeys the normal rules.
- Priority at each rising edge, with clear=1:
  1. load=1: out<=inp; rld<=inp; done<=0. count is ignored.
  2. load=0, count=1, out!=0: out<=out-1; done<=0.
  3. load=0, count=1, out==0: out<=(AUTO_RELOAD ? rld : all-ones); done<=1.
  4. load=0, count=0: out holds; done<=0.
- Latency:
  - A load is visible on out one cycle after the edge.
  - Each decrement is visible one cycle after the edge.
  - done is asserted in the cycle following the borrow cycle.
- borrow:
  - It is purely combinational and valid in the same cycle that out==0 and count=1.
  - Cascading: the next stage's count input is driven by this stage's borrow, and both stages share clock and clear.
  - borrow must not glitch high while load=1.
- zero is independent of count and load.
- Auto-reload with rld=0: counting at out=0 reloads 0. borrow stays high and done pulses every counting cycle; this is legal, not an error.
- Auto-reload period: with rld=N and count held at 1, done pulses once every N+1 cycles.
- Load of 0 while counting: out=0 next cycle. borrow asserts if count stays high.
- No X propagation: out must never be X after reset, even if inp is X while load=0.

Test Plan:
- Reset / load: assert clear=0 mid-count at out=5 -> out=0, done=0 immediately, before any edge; release, then load inp=9 -> out=9 after one edge.
- Free-run, WIDTH=4, AUTO_RELOAD=0: load 3, then count=1 for 5 cycles -> out sequence 3,2,1,0,15,14; borrow high only while out=0; done high exactly in the cycle out=15.
- Auto-reload, WIDTH=4, AUTO_RELOAD=1: load 2, then count=1 -> out sequence 2,1,0,2,1,0,2; done pulses every 3 cycles; borrow high only when out=0.
- Simultaneous: at out=0 apply load=1, count=1, inp=7 -> out=7, borrow=0 during that cycle, done=0 next cycle.
- Hold: count=0, load=0 for 4 cycles at out=6 -> out stays 6, done=0, borrow=0, zero=0.
- Cascade: two WIDTH=4 instances with low.borrow driving high.count, loaded to 0x10 -> after one count cycle 0x0F; after 16 more, 0xFF (full wrap); high.borrow asserted only at 0x00 with count=1.

Source files
------------

// File: rtl/gate_down_counter.sv
// gate_down_counter: loadable binary down-counter with borrow for cascading,
// a registered done pulse after each borrow, and optional auto-reload.
// External vectors are declared [0:WIDTH-1] with index 0 as the LSB; the
// arithmetic runs on an internal [WIDTH-1:0] copy so the bit order is explicit.
module gate_down_counter #(
    parameter int WIDTH       = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             count,
    input  logic             load,
    input  logic [0:WIDTH-1] inp,
    output logic [0:WIDTH-1] out,
    output logic             borrow,
    output logic             zero,
    output logic             done
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] inp_le;
    logic [WIDTH-1:0] rld;

    // Map the LSB-at-index-0 port vectors onto conventional little-endian vectors.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bits
        assign inp_le[i] = inp[i];
        assign out[i]    = cnt_q[i];
    end

    // zero ignores count/load; borrow is gated by ~load so it cannot pulse during a load.
    assign zero   = (cnt_q == '0);
    assign borrow = count & ~load & zero;

    // Wrap target: the last loaded value in auto-reload mode, all-ones otherwise.
    if (AUTO_RELOAD) begin : g_reload
        // Capture the load value so the counter can restart from it after a borrow.
        always_ff @(posedge clock or negedge clear) begin
            if (!clear) begin
                rld <= '0;
            end else if (load) begin
                rld <= inp_le;
            end
        end
    end else begin : g_no_reload
        assign rld = '1;
    end

    // Count register and done flop: load beats count, count at zero wraps and flags done.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            cnt_q <= '0;
            done  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, and done defaults low each edge so it is a one-cycle pulse.
            done <= 1'b0;
            if (load) begin
                cnt_q <= inp_le;
            end else if (count) begin
                if (zero) begin
                    cnt_q <= rld;
                    done  <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_gate_down_counter.sv
// Testbench for gate_down_counter: a free-running instance (AUTO_RELOAD=0),
// an auto-reload instance (AUTO_RELOAD=1) sharing its inputs, and a two-stage
// 8-bit cascade. A driver pushes expected per-cycle outputs from a behavioural
// model into a queue; a monitor pops and compares them mid-cycle.
module tb_gate_down_counter;

    logic clock;
    logic clear;
    logic count;
    logic load;
    logic [0:3] inp_v;
    logic ccount;
    logic cload;
    logic [0:3] cinp_lo;
    logic [0:3] cinp_hi;

    logic [0:3] a_out, b_out, lo_out, hi_out;
    logic a_bor, a_zero, a_done;
    logic b_bor, b_zero, b_done;
    logic lo_bor, lo_zero, lo_done;
    logic hi_bor, hi_zero, hi_done;

    gate_down_counter #(.WIDTH(4), .AUTO_RELOAD(1'b0)) u_free (
        .clock(clock), .clear(clear), .count(count), .load(load), .inp(inp_v),
        .out(a_out), .borrow(a_bor), .zero(a_zero), .done(a_done));

    gate_down_counter #(.WIDTH(4), .AUTO_RELOAD(1'b1)) u_reload (
        .clock(clock), .clear(clear), .count(count), .load(load), .inp(inp_v),
        .out(b_out), .borrow(b_bor), .zero(b_zero), .done(b_done));

    gate_down_counter #(.WIDTH(4), .AUTO_RELOAD(1'b0)) u_lo (
        .clock(clock), .clear(clear), .count(ccount), .load(cload), .inp(cinp_lo),
        .out(lo_out), .borrow(lo_bor), .zero(lo_zero), .done(lo_done));

    gate_down_counter #(.WIDTH(4), .AUTO_RELOAD(1'b0)) u_hi (
        .clock(clock), .clear(clear), .count(lo_bor), .load(cload), .inp(cinp_hi),
        .out(hi_out), .borrow(hi_bor), .zero(hi_zero), .done(hi_done));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        int a_out; int a_bor; int a_zero; int a_done;
        int b_out; int b_bor; int b_zero; int b_done;
        int c_val; int c_lo_bor; int c_hi_bor; int c_done;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Stimulus requested for the next cycle.
    bit drv_clear, drv_load, drv_count, drv_inp_x, drv_cload, drv_ccount;
    int drv_inp, drv_cinp;

    // Reference model state: plain integers following the counter rules.
    int m_a, m_a_done;
    int m_b, m_b_rld, m_b_done;
    int m_c, m_c_done;

    // Value of an LSB-at-index-0 vector.
    function automatic int vec_val(input logic [0:3] v);
        int r = 0;
        for (int i = 0; i < 4; i++) if (v[i] === 1'b1) r += (1 << i);
        return r;
    endfunction

    function automatic logic [0:3] val_vec(input int val);
        logic [3:0] t = val[3:0];
        logic [0:3] v;
        for (int i = 0; i < 4; i++) v[i] = t[i];
        return v;
    endfunction

    task automatic check(input string name, input int c, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, c, act, req);
        end
    endtask

    // Apply one cycle of stimulus at the falling edge, record the expected
    // outputs for that cycle, then advance the model across the next rising edge.
    task automatic step();
        exp_t e;
        @(negedge clock);
        cyc++;
        clear   = drv_clear;
        load    = drv_load;
        count   = drv_count;
        inp_v   = drv_inp_x ? 4'bxxxx : val_vec(drv_inp);
        cload   = drv_cload;
        ccount  = drv_ccount;
        cinp_lo = val_vec(drv_cinp % 16);
        cinp_hi = val_vec(drv_cinp / 16);
        if (!drv_clear) begin
            m_a = 0; m_a_done = 0;
            m_b = 0; m_b_rld = 0; m_b_done = 0;
            m_c = 0; m_c_done = 0;
        end
        e.cyc      = cyc;
        e.a_out    = m_a;
        e.a_zero   = int'(m_a == 0);
        e.a_bor    = int'(drv_count && !drv_load && m_a == 0);
        e.a_done   = m_a_done;
        e.b_out    = m_b;
        e.b_zero   = int'(m_b == 0);
        e.b_bor    = int'(drv_count && !drv_load && m_b == 0);
        e.b_done   = m_b_done;
        e.c_val    = m_c;
        e.c_lo_bor = int'(drv_ccount && !drv_cload && (m_c % 16) == 0);
        e.c_hi_bor = int'(drv_ccount && !drv_cload && m_c == 0);
        e.c_done   = m_c_done;
        exp_q.push_back(e);
        if (drv_clear) begin
            if (drv_load) begin
                m_a = drv_inp; m_a_done = 0;
                m_b = drv_inp; m_b_rld = drv_inp; m_b_done = 0;
            end else if (drv_count) begin
                m_a_done = int'(m_a == 0);
                m_a      = (m_a + 15) % 16;
                m_b_done = int'(m_b == 0);
                m_b      = (m_b == 0) ? m_b_rld : m_b - 1;
            end else begin
                m_a_done = 0;
                m_b_done = 0;
            end
            m_c_done = e.c_hi_bor;
            if (drv_cload) m_c = drv_cinp;
            else if (drv_ccount) m_c = (m_c + 255) % 256;
        end
    endtask

    task automatic set_ab(input bit ld, input bit cn, input int v);
        drv_load  = ld;
        drv_count = cn;
        drv_inp   = v;
        drv_inp_x = 1'b0;
    endtask

    // Monitor: compare whatever the driver queued for this cycle, mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("free_out",    e.cyc, vec_val(a_out), e.a_out);
                check("free_borrow", e.cyc, int'(a_bor),    e.a_bor);
                check("free_zero",   e.cyc, int'(a_zero),   e.a_zero);
                check("free_done",   e.cyc, int'(a_done),   e.a_done);
                check("rld_out",     e.cyc, vec_val(b_out), e.b_out);
                check("rld_borrow",  e.cyc, int'(b_bor),    e.b_bor);
                check("rld_zero",    e.cyc, int'(b_zero),   e.b_zero);
                check("rld_done",    e.cyc, int'(b_done),   e.b_done);
                check("casc_val",    e.cyc, vec_val(hi_out) * 16 + vec_val(lo_out), e.c_val);
                check("casc_lo_bor", e.cyc, int'(lo_bor),   e.c_lo_bor);
                check("casc_hi_bor", e.cyc, int'(hi_bor),   e.c_hi_bor);
                check("casc_done",   e.cyc, int'(hi_done),  e.c_done);
            end
        end
    end

    initial begin
        clear = 1'b0; load = 1'b0; count = 1'b0; inp_v = '0;
        cload = 1'b0; ccount = 1'b0; cinp_lo = '0; cinp_hi = '0;
        drv_clear = 1'b0; drv_cload = 1'b0; drv_ccount = 1'b0; drv_cinp = 0;
        set_ab(1'b0, 1'b0, 0);
        m_a = 0; m_a_done = 0; m_b = 0; m_b_rld = 0; m_b_done = 0; m_c = 0; m_c_done = 0;

        // Reset state.
        repeat (2) step();
        drv_clear = 1'b1;

        // Load 7, count down to 5, then drop clear mid-count: zero before any edge.
        set_ab(1'b1, 1'b0, 7); step();
        set_ab(1'b0, 1'b1, 0); repeat (2) step();
        drv_clear = 1'b0; step();
        drv_clear = 1'b1;
        set_ab(1'b1, 1'b0, 9); step();
        set_ab(1'b0, 1'b0, 0); step();

        // Free-run from 3 through the wrap.
        set_ab(1'b1, 1'b0, 3); step();
        set_ab(1'b0, 1'b1, 0); repeat (6) step();

        // Auto-reload period from 2.
        set_ab(1'b1, 1'b0, 2); step();
        set_ab(1'b0, 1'b1, 0); repeat (8) step();

        // Load and count together at out==0: load wins, no borrow.
        set_ab(1'b1, 1'b0, 0); step();
        set_ab(1'b1, 1'b1, 7); step();
        set_ab(1'b0, 1'b0, 0); step();

        // Hold at 6 with an undriven load value.
        set_ab(1'b1, 1'b0, 6); step();
        set_ab(1'b0, 1'b0, 0); drv_inp_x = 1'b1; repeat (4) step();

        // Load 0 while counting, then auto-reload with rld=0.
        set_ab(1'b0, 1'b1, 0); step();
        set_ab(1'b1, 1'b1, 0); step();
        set_ab(1'b0, 1'b1, 0); repeat (4) step();

        // Cascade: load 0x10, count through 0x0F down to 0xFF.
        drv_cload = 1'b1; drv_cinp = 16; step();
        drv_cload = 1'b0; drv_ccount = 1'b1; repeat (18) step();

        // Randomised traffic on all instances with occasional async clears.
        for (int i = 0; i < 400; i++) begin
            drv_clear  = ($urandom_range(0, 59) != 0);
            drv_load   = ($urandom_range(0, 5) == 0);
            drv_count  = ($urandom_range(0, 3) != 0);
            drv_inp    = int'($urandom_range(0, 15));
            drv_inp_x  = 1'b0;
            drv_cload  = ($urandom_range(0, 9) == 0);
            drv_ccount = ($urandom_range(0, 4) != 0);
            drv_cinp   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) * 16
                                                     : int'($urandom_range(0, 255));
            step();
        end

        // Drain: every queued expectation must have been consumed.
        drv_clear = 1'b1; set_ab(1'b0, 1'b0, 0); drv_cload = 1'b0; drv_ccount = 1'b0;
        step();
        repeat (2) @(negedge clock);
        #4;
        check("queue_drained", cyc, exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
